// File: rtl/net_sched_pkg.sv
// Shared types and width helpers for the net_engine frame scheduler.
package net_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_DRAIN     = 2'd3
    } state_t;

    localparam int FRAME_CNT_W = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/net_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after last_grant+1.
module net_sched_rr_arbiter
    import net_sched_pkg::*;
#(
    parameter int C_NUM_REQ = 4
) (
    input  logic [C_NUM_REQ-1:0]        req,
    input  logic [idx_w(C_NUM_REQ)-1:0] last_grant,
    output logic                        valid,
    output logic [idx_w(C_NUM_REQ)-1:0] idx
);

    localparam int IDW = idx_w(C_NUM_REQ);

    int pos;

    // Scan farthest offset first so the nearest requester is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = C_NUM_REQ; k >= 1; k--) begin
            pos = (int'(last_grant) + k) % C_NUM_REQ;
            if (req[IDW'(pos)]) begin
                valid = 1'b1;
                idx   = IDW'(pos);
            end
        end
    end

endmodule

// File: rtl/net_engine_sched.sv
// Round-robin frame scheduler sharing one net_engine between AXIS requesters.
// Optional WAIT_DONE watchdog enabled by defining NET_SCHED_TIMEOUT_EN.
module net_engine_sched
    import net_sched_pkg::*;
#(
    parameter int C_NUM_REQ        = 4,
    parameter int C_TDATA_WIDTH    = 32,
    parameter int C_NET_CELL_COUNT = 100,
    parameter int C_TIMEOUT_CYCLES = 4096
) (
    input  logic                                 aclk,
    input  logic                                 areset,
    input  logic                                 enable,
    input  logic [C_NUM_REQ-1:0]                 s_axis_tvalid,
    input  logic [C_NUM_REQ*C_TDATA_WIDTH-1:0]   s_axis_tdata,
    output logic [C_NUM_REQ-1:0]                 s_axis_tready,
    output logic                                 eng_s_tvalid,
    output logic [C_TDATA_WIDTH-1:0]             eng_s_tdata,
    output logic                                 eng_s_tlast,
    input  logic                                 eng_s_tready,
    input  logic                                 eng_done,
    input  logic                                 eng_m_tvalid,
    input  logic [C_TDATA_WIDTH-1:0]             eng_m_tdata,
    output logic                                 eng_m_tready,
    output logic                                 m_axis_tvalid,
    output logic [C_TDATA_WIDTH-1:0]             m_axis_tdata,
    output logic                                 m_axis_tlast,
    output logic [idx_w(C_NUM_REQ)-1:0]          m_axis_tdest,
    input  logic                                 m_axis_tready,
    output logic                                 busy,
    output logic [idx_w(C_NUM_REQ)-1:0]          grant_id,
    output logic [FRAME_CNT_W-1:0]               frame_count,
    output logic                                 err_timeout
);

    localparam int IDW = idx_w(C_NUM_REQ);
    localparam int CW  = cnt_w(C_NET_CELL_COUNT);
    localparam logic [CW-1:0] LAST_WORD = CW'(C_NET_CELL_COUNT - 1);

    state_t state;
    state_t state_nx;

    logic [CW-1:0]            word_cnt;
    logic [IDW-1:0]           last_grant;
    logic                     arb_valid;
    logic [IDW-1:0]           arb_idx;
    logic                     last_word;
    logic                     in_hs;
    logic                     out_hs;
    logic                     timeout;
    logic [C_TDATA_WIDTH-1:0] req_data [C_NUM_REQ];

    for (genvar i = 0; i < C_NUM_REQ; i++) begin : g_slice
        assign req_data[i] = s_axis_tdata[i*C_TDATA_WIDTH +: C_TDATA_WIDTH];
    end

    net_sched_rr_arbiter #(
        .C_NUM_REQ (C_NUM_REQ)
    ) u_arb (
        .req        (s_axis_tvalid),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .idx        (arb_idx)
    );

    assign last_word = (word_cnt == LAST_WORD);
    assign in_hs     = (state == ST_LOAD) && s_axis_tvalid[grant_id] && eng_s_tready;
    assign out_hs    = (state == ST_DRAIN) && eng_m_tvalid && m_axis_tready;
    assign busy      = (state != ST_IDLE);

`ifdef NET_SCHED_TIMEOUT_EN
    localparam int TW = cnt_w(C_TIMEOUT_CYCLES);

    logic [TW-1:0] wd_cnt;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state == ST_WAIT_DONE) wd_cnt <= wd_cnt + TW'(1);
            else wd_cnt <= '0;
            if (timeout) err_timeout <= 1'b1;
        end
    end

    assign timeout = (state == ST_WAIT_DONE) && !eng_done &&
                     (wd_cnt == TW'(C_TIMEOUT_CYCLES - 1));
`else
    assign timeout     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= ST_IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:      if (enable && arb_valid) state_nx = ST_LOAD;
            ST_LOAD:      if (in_hs && last_word) state_nx = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (eng_done) state_nx = ST_DRAIN;
                else if (timeout) state_nx = ST_IDLE;
            end
            ST_DRAIN:     if (out_hs && last_word) state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = '0;
        eng_s_tvalid  = 1'b0;
        eng_s_tdata   = '0;
        eng_s_tlast   = 1'b0;
        eng_m_tready  = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tdest  = '0;
        unique case (state)
            ST_LOAD: begin
                s_axis_tready[grant_id] = eng_s_tready;
                eng_s_tvalid = s_axis_tvalid[grant_id];
                eng_s_tdata  = req_data[grant_id];
                eng_s_tlast  = last_word;
            end
            ST_DRAIN: begin
                eng_m_tready  = m_axis_tready;
                m_axis_tvalid = eng_m_tvalid;
                m_axis_tdata  = eng_m_tdata;
                m_axis_tlast  = last_word;
                m_axis_tdest  = grant_id;
            end
            default: ;
        endcase
    end

    // Word counter restarts on every state change, so it indexes both phases.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            grant_id    <= '0;
            last_grant  <= IDW'(C_NUM_REQ - 1);
            word_cnt    <= '0;
            frame_count <= '0;
        end else begin
            if (state == ST_IDLE && state_nx == ST_LOAD) grant_id <= arb_idx;
            if (state != state_nx) word_cnt <= '0;
            else if (in_hs || out_hs) word_cnt <= word_cnt + CW'(1);
            if (state != ST_IDLE && state_nx == ST_IDLE) last_grant <= grant_id;
            if (state == ST_DRAIN && state_nx == ST_IDLE)
                frame_count <= frame_count + FRAME_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_net_engine_sched.sv
// Directed bench for net_engine_sched with a behavioural engine/requester model.
module tb_net_engine_sched;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int NC = 100;
    localparam int TO = 64;
    localparam logic [W-1:0] K = 32'h5A5A_5A5A;

    logic            aclk = 1'b0;
    logic            areset;
    logic            enable;
    logic [NR-1:0]   s_axis_tvalid;
    logic [NR*W-1:0] s_axis_tdata;
    logic [NR-1:0]   s_axis_tready;
    logic            eng_s_tvalid;
    logic [W-1:0]    eng_s_tdata;
    logic            eng_s_tlast;
    logic            eng_s_tready;
    logic            eng_done;
    logic            eng_m_tvalid;
    logic [W-1:0]    eng_m_tdata;
    logic            eng_m_tready;
    logic            m_axis_tvalid;
    logic [W-1:0]    m_axis_tdata;
    logic            m_axis_tlast;
    logic [1:0]      m_axis_tdest;
    logic            m_axis_tready;
    logic            busy;
    logic [1:0]      grant_id;
    logic [15:0]     frame_count;
    logic            err_timeout;

    net_engine_sched #(
        .C_NUM_REQ        (NR),
        .C_TDATA_WIDTH    (W),
        .C_NET_CELL_COUNT (NC),
        .C_TIMEOUT_CYCLES (TO)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .enable        (enable),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tready (s_axis_tready),
        .eng_s_tvalid  (eng_s_tvalid),
        .eng_s_tdata   (eng_s_tdata),
        .eng_s_tlast   (eng_s_tlast),
        .eng_s_tready  (eng_s_tready),
        .eng_done      (eng_done),
        .eng_m_tvalid  (eng_m_tvalid),
        .eng_m_tdata   (eng_m_tdata),
        .eng_m_tready  (eng_m_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .grant_id      (grant_id),
        .frame_count   (frame_count),
        .err_timeout   (err_timeout)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;

    bit [NR-1:0] req_want;
    int          src_ptr [NR];
    bit          vgap_en, trdy_tog, mrdy_tog, done_block;
    int          en_drop_at;
    int          cyc = 0;
    int          e_in, e_out;
    bit          e_done_next, e_out_on;
    logic [W-1:0] e_mem [NC];

    int in_hs_cnt, in_bad, last_cnt, out_cnt, out_bad, dest_bad;
    int gnt_seen, first_in_cyc, start_cyc, exp_owner;
    logic [W-1:0] out_first, out_final;

    task automatic reset_model();
        req_want    = '0;
        vgap_en     = 0;
        trdy_tog    = 0;
        mrdy_tog    = 0;
        done_block  = 0;
        en_drop_at  = -1;
        e_in        = 0;
        e_out       = 0;
        e_done_next = 0;
        e_out_on    = 0;
        for (int i = 0; i < NR; i++) src_ptr[i] = 0;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        eng_s_tready  = 1'b0;
        eng_done      = 1'b0;
        eng_m_tvalid  = 1'b0;
        eng_m_tdata   = '0;
        m_axis_tready = 1'b0;
    endtask

    task automatic clear_stats();
        in_hs_cnt    = 0;
        in_bad       = 0;
        last_cnt     = 0;
        out_cnt      = 0;
        out_bad      = 0;
        dest_bad     = 0;
        gnt_seen     = -1;
        first_in_cyc = -1;
        start_cyc    = cyc;
    endtask

    // One clock: drive at negedge, observe 1 ns later, update the model.
    task automatic cycle();
        logic [W-1:0] d;
        int hs_i;
        int nrdy;
        @(negedge aclk);
        if (en_drop_at >= 0 && e_in >= en_drop_at) begin
            enable     = 1'b0;
            en_drop_at = -1;
        end
        for (int i = 0; i < NR; i++) begin
            s_axis_tvalid[i] = req_want[i] && !(vgap_en && (cyc % 3 == 1));
            d = {8'(i), 24'(src_ptr[i])};
            s_axis_tdata[i*W +: W] = d;
        end
        eng_s_tready = trdy_tog ? (cyc % 2 == 0) : 1'b1;
        eng_done = e_done_next;
        if (e_done_next) begin
            e_done_next = 0;
            e_out_on    = 1;
        end
        eng_m_tvalid  = e_out_on && (e_out < NC);
        eng_m_tdata   = (e_out < NC) ? (e_mem[e_out] ^ K) : '0;
        m_axis_tready = mrdy_tog ? (cyc % 2 == 1) : 1'b1;
        #1;
        hs_i = -1;
        nrdy = 0;
        for (int i = 0; i < NR; i++) begin
            if (s_axis_tready[i]) nrdy++;
            if (s_axis_tvalid[i] && s_axis_tready[i]) hs_i = i;
        end
        if (nrdy > 1) in_bad++;
        if (eng_s_tvalid && eng_s_tready) begin
            if (hs_i < 0) in_bad++;
            else begin
                d = {8'(hs_i), 24'(src_ptr[hs_i])};
                if (eng_s_tdata !== d) in_bad++;
                if (in_hs_cnt == 0) begin
                    gnt_seen     = hs_i;
                    first_in_cyc = cyc;
                end
                src_ptr[hs_i]++;
            end
            if (eng_s_tlast !== (e_in == NC - 1)) in_bad++;
            if (eng_s_tlast) last_cnt++;
            if (e_in < NC) e_mem[e_in] = eng_s_tdata;
            e_in++;
            in_hs_cnt++;
            if (e_in == NC && !done_block) e_done_next = 1;
        end else if (hs_i >= 0) in_bad++;
        if (m_axis_tvalid && m_axis_tready) begin
            if (m_axis_tdata !== (e_mem[e_out] ^ K)) out_bad++;
            if (m_axis_tlast !== (e_out == NC - 1)) out_bad++;
            if (int'(m_axis_tdest) != exp_owner) dest_bad++;
            if (out_cnt == 0) out_first = m_axis_tdata;
            out_final = m_axis_tdata;
            e_out++;
            out_cnt++;
            if (e_out == NC) begin
                e_in     = 0;
                e_out    = 0;
                e_out_on = 0;
            end
        end
        cyc++;
    endtask

    task automatic run_out(input int n, input int budget, output bit to);
        int k;
        to = 0;
        k  = 0;
        while (out_cnt < n) begin
            if (k >= budget) begin
                to = 1;
                break;
            end
            cycle();
            k++;
        end
    endtask

    task automatic apply_reset();
        @(negedge aclk);
        areset = 1'b1;
        enable = 1'b0;
        reset_model();
        repeat (2) @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge aclk);
        areset = 1'b1;
        enable = 1'b0;
        reset_model();
        #1;
        n_cmp++;
        if (busy !== 1'b0 || grant_id !== 2'd0 || frame_count !== 16'd0 ||
            err_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_regs: busy=%b grant=%0d frames=%0d err=%b, want 0/0/0/0",
                     busy, grant_id, frame_count, err_timeout);
        end
        n_cmp++;
        if (s_axis_tready !== 4'd0 || eng_s_tvalid !== 1'b0 ||
            eng_s_tlast !== 1'b0 || eng_m_tready !== 1'b0 ||
            m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 ||
            m_axis_tdest !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_streams: rdy=%b esv=%b esl=%b emr=%b mv=%b ml=%b md=%0d, want all 0",
                     s_axis_tready, eng_s_tvalid, eng_s_tlast, eng_m_tready,
                     m_axis_tvalid, m_axis_tlast, m_axis_tdest);
        end
        repeat (2) @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic test_single();
        bit to;
        apply_reset();
        enable    = 1'b1;
        req_want  = 4'b0001;
        exp_owner = 0;
        clear_stats();
        run_out(NC, 600, to);
        req_want = '0;
        cycle();
        n_cmp++;
        if (to || first_in_cyc - start_cyc != 1 || gnt_seen != 0) begin
            n_bad++;
            $display("FAIL single_grant: to=%b latency=%0d owner=%0d, want 0/1/0",
                     to, first_in_cyc - start_cyc, gnt_seen);
        end
        n_cmp++;
        if (in_hs_cnt != NC || in_bad != 0 || last_cnt != 1) begin
            n_bad++;
            $display("FAIL single_load: words=%0d bad=%0d lasts=%0d, want %0d/0/1",
                     in_hs_cnt, in_bad, last_cnt, NC);
        end
        n_cmp++;
        if (out_cnt != NC || out_bad != 0 || dest_bad != 0) begin
            n_bad++;
            $display("FAIL single_drain: words=%0d bad=%0d dest_bad=%0d, want %0d/0/0",
                     out_cnt, out_bad, dest_bad, NC);
        end
        n_cmp++;
        if (out_first !== K || out_final !== (32'd99 ^ K)) begin
            n_bad++;
            $display("FAIL single_data: first=%h last=%h, want %h/%h",
                     out_first, out_final, K, 32'd99 ^ K);
        end
        n_cmp++;
        if (busy !== 1'b0 || frame_count !== 16'd1) begin
            n_bad++;
            $display("FAIL single_end: busy=%b frames=%0d, want 0/1", busy, frame_count);
        end
    endtask

    task automatic test_round_robin();
        bit to;
        apply_reset();
        enable   = 1'b1;
        req_want = 4'b1010;
        for (int f = 0; f < 4; f++) begin
            clear_stats();
            exp_owner = (f % 2 == 0) ? 1 : 3;
            run_out(NC, 800, to);
            n_cmp++;
            if (to || gnt_seen != exp_owner || dest_bad != 0 ||
                out_bad != 0 || in_bad != 0) begin
                n_bad++;
                $display("FAIL rr_frame%0d: to=%b owner=%0d dest_bad=%0d bad=%0d/%0d, want owner %0d",
                         f, to, gnt_seen, dest_bad, in_bad, out_bad, exp_owner);
            end
        end
        req_want = '0;
        repeat (2) cycle();
        n_cmp++;
        if (frame_count !== 16'd4) begin
            n_bad++;
            $display("FAIL rr_count: frames=%0d, want 4", frame_count);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        req_want  = 4'b0001;
        trdy_tog  = 1;
        vgap_en   = 1;
        mrdy_tog  = 1;
        exp_owner = 0;
        clear_stats();
        run_out(NC, 2000, to);
        trdy_tog = 0;
        vgap_en  = 0;
        mrdy_tog = 0;
        req_want = '0;
        cycle();
        n_cmp++;
        if (to || gnt_seen != 0 || in_hs_cnt != NC || in_bad != 0 || last_cnt != 1) begin
            n_bad++;
            $display("FAIL bp_load: to=%b owner=%0d words=%0d bad=%0d lasts=%0d, want 0/0/%0d/0/1",
                     to, gnt_seen, in_hs_cnt, in_bad, last_cnt, NC);
        end
        n_cmp++;
        if (out_cnt != NC || out_bad != 0 || frame_count !== 16'd5) begin
            n_bad++;
            $display("FAIL bp_drain: words=%0d bad=%0d frames=%0d, want %0d/0/5",
                     out_cnt, out_bad, frame_count, NC);
        end
    endtask

    task automatic test_enable_drop();
        bit to;
        int bc;
        enable     = 1'b1;
        req_want   = 4'b0001;
        en_drop_at = 50;
        exp_owner  = 0;
        clear_stats();
        run_out(NC, 800, to);
        bc = 0;
        repeat (20) begin
            cycle();
            if (busy !== 1'b0 || s_axis_tready !== 4'd0) bc++;
        end
        n_cmp++;
        if (to || out_cnt != NC || out_bad != 0 || dest_bad != 0) begin
            n_bad++;
            $display("FAIL endrop_frame: to=%b words=%0d bad=%0d, want 0/%0d/0",
                     to, out_cnt, out_bad, NC);
        end
        n_cmp++;
        if (bc != 0 || frame_count !== 16'd6) begin
            n_bad++;
            $display("FAIL endrop_idle: busy_cycles=%0d frames=%0d, want 0/6", bc, frame_count);
        end
        req_want = '0;
        cycle();
        enable = 1'b1;
    endtask

    task automatic test_timeout();
`ifdef NET_SCHED_TIMEOUT_EN
        bit to;
        bit idle_seen;
        int wc;
        int k;
        logic [15:0] fc0;
        fc0        = frame_count;
        req_want   = 4'b0011;
        done_block = 1;
        exp_owner  = 1;
        clear_stats();
        k = 0;
        while (in_hs_cnt < NC && k < 800) begin
            cycle();
            k++;
        end
        wc = 0;
        idle_seen = 0;
        for (int j = 0; j < 200 && !idle_seen; j++) begin
            cycle();
            if (busy) wc++;
            else idle_seen = 1;
        end
        n_cmp++;
        if (in_hs_cnt != NC || gnt_seen != 1 || !idle_seen || wc != TO) begin
            n_bad++;
            $display("FAIL to_wait: words=%0d owner=%0d idle=%b wait_cycles=%0d, want %0d/1/1/%0d",
                     in_hs_cnt, gnt_seen, idle_seen, wc, NC, TO);
        end
        n_cmp++;
        if (err_timeout !== 1'b1 || frame_count !== fc0) begin
            n_bad++;
            $display("FAIL to_flag: err=%b frames=%0d, want 1/%0d", err_timeout, frame_count, fc0);
        end
        e_in       = 0;
        done_block = 0;
        exp_owner  = 0;
        clear_stats();
        run_out(NC, 800, to);
        req_want = '0;
        cycle();
        n_cmp++;
        if (to || gnt_seen != 0 || out_bad != 0 || err_timeout !== 1'b1 ||
            frame_count !== fc0 + 16'd1) begin
            n_bad++;
            $display("FAIL to_next: to=%b owner=%0d bad=%0d err=%b frames=%0d, want 0/0/0/1/%0d",
                     to, gnt_seen, out_bad, err_timeout, frame_count, fc0 + 16'd1);
        end
`else
        n_cmp++;
        if (err_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL to_disabled: err=%b, want 0", err_timeout);
        end
`endif
    endtask

    task automatic test_reset_mid_drain();
        bit to;
        enable    = 1'b1;
        req_want  = 4'b0101;
        exp_owner = 2;
        clear_stats();
        run_out(40, 800, to);
        n_cmp++;
        if (to || gnt_seen != 2 || out_bad != 0) begin
            n_bad++;
            $display("FAIL rst_pre: to=%b owner=%0d bad=%0d, want 0/2/0", to, gnt_seen, out_bad);
        end
        #2;
        areset = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || grant_id !== 2'd0 || frame_count !== 16'd0 ||
            err_timeout !== 1'b0 || s_axis_tready !== 4'd0 ||
            m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 ||
            m_axis_tdest !== 2'd0 || eng_m_tready !== 1'b0 || eng_s_tvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_async: busy=%b grant=%0d frames=%0d err=%b rdy=%b mv=%b emr=%b, want all 0",
                     busy, grant_id, frame_count, err_timeout, s_axis_tready,
                     m_axis_tvalid, eng_m_tready);
        end
        @(negedge aclk);
        reset_model();
        areset    = 1'b0;
        enable    = 1'b1;
        req_want  = 4'b0101;
        exp_owner = 0;
        clear_stats();
        run_out(NC, 800, to);
        req_want = '0;
        cycle();
        n_cmp++;
        if (to || gnt_seen != 0 || out_bad != 0 || dest_bad != 0 || frame_count !== 16'd1) begin
            n_bad++;
            $display("FAIL rst_after: to=%b owner=%0d bad=%0d dest_bad=%0d frames=%0d, want 0/0/0/0/1",
                     to, gnt_seen, out_bad, dest_bad, frame_count);
        end
    endtask

    initial begin
        areset = 1'b1;
        enable = 1'b0;
        reset_model();
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_enable_drop();
        test_timeout();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
